// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around the unified-memory arbiter.
// slave is the arbiter's view; master is the requesters/memory environment.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Fetch requester
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_flush;
    logic              if_ack;
    logic [DW-1:0]     if_rdata;
    // Data requester
    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_wstrb;
    logic              d_ack;
    logic [DW-1:0]     d_rdata;
    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;
    logic              mem_ack;
    logic [DW-1:0]     mem_rdata;
    // Pipeline stalls
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_ack, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ack, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_ack, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ack, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Data side wins by default; a saturating counter forces a fetch grant after
// STARVE_MAX data grants taken while a fetch was waiting.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mem_port_arbiter_if.slave io_bus
);
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e            r_state, w_state_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [AW-1:0]     r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0]     r_mem_wdata, w_mem_wdata_nxt;
    logic [DW/8-1:0]   r_mem_wstrb, w_mem_wstrb_nxt;
    logic              r_if_ack, w_if_ack_nxt;
    logic              r_d_ack, w_d_ack_nxt;
    logic [DW-1:0]     r_if_rdata, w_if_rdata_nxt;
    logic [DW-1:0]     r_d_rdata, w_d_rdata_nxt;
    logic [CW-1:0]     r_starve_cnt, w_starve_nxt;
    logic              r_drop, w_drop_nxt;

    logic              w_ri, w_rd, w_starve_full, w_grant_d, w_grant_i;

    // Effective requests (a requester is ignored in its own ack cycle) and idle-time grant.
    always_comb begin
        w_ri          = io_bus.if_req & ~io_bus.if_flush & ~r_if_ack;
        w_rd          = io_bus.d_req & ~r_d_ack;
        w_starve_full = (r_starve_cnt == CW'(STARVE_MAX));
        w_grant_d     = (r_state == StIdle) & w_rd & ~(w_ri & w_starve_full);
        w_grant_i     = (r_state == StIdle) & ~w_grant_d & w_ri;
    end

    // Next-state, memory-side register loads, ack pulses and starvation bookkeeping.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wstrb_nxt = r_mem_wstrb;
        w_if_ack_nxt    = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_starve_nxt    = r_starve_cnt;
        w_drop_nxt      = r_drop;

        case (r_state)
            StIdle: begin
                if (w_grant_d) begin
                    w_state_nxt     = StBusyD;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = io_bus.d_we;
                    w_mem_addr_nxt  = io_bus.d_addr;
                    w_mem_wdata_nxt = io_bus.d_wdata;
                    w_mem_wstrb_nxt = io_bus.d_we ? io_bus.d_wstrb : '0;
                    if (w_ri && !w_starve_full) begin
                        w_starve_nxt = r_starve_cnt + CW'(1);
                    end
                end else if (w_grant_i) begin
                    w_state_nxt     = StBusyI;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = io_bus.if_addr;
                    w_mem_wdata_nxt = '0;
                    w_mem_wstrb_nxt = '0;
                    w_starve_nxt    = '0;
                end
            end
            StBusyI: begin
                if (io_bus.if_flush) begin
                    w_drop_nxt = 1'b1;
                end
                if (io_bus.mem_ack) begin
                    w_state_nxt   = StIdle;
                    w_mem_req_nxt = 1'b0;
                    w_drop_nxt    = 1'b0;
                    // A flush on the completion edge also kills the fetch.
                    if (!(r_drop || io_bus.if_flush)) begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = io_bus.mem_rdata;
                    end
                end
            end
            StBusyD: begin
                if (io_bus.mem_ack) begin
                    w_state_nxt   = StIdle;
                    w_mem_req_nxt = 1'b0;
                    w_d_ack_nxt   = 1'b1;
                    w_d_rdata_nxt = io_bus.mem_rdata;
                end
            end
            default: begin
                w_state_nxt   = StIdle;
                w_mem_req_nxt = 1'b0;
            end
        endcase

        if (!io_bus.if_req) begin
            w_starve_nxt = '0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_starve_cnt <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_wstrb  <= w_mem_wstrb_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_d_ack      <= w_d_ack_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_drop       <= w_drop_nxt;
        end
    end

    assign io_bus.mem_req   = r_mem_req;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.mem_wstrb = r_mem_wstrb;
    assign io_bus.if_ack    = r_if_ack;
    assign io_bus.if_rdata  = r_if_rdata;
    assign io_bus.d_ack     = r_d_ack;
    assign io_bus.d_rdata   = r_d_rdata;
    assign io_bus.stall_if  = io_bus.if_req & ~r_if_ack;
    assign io_bus.stall_mem = io_bus.d_req & ~r_d_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: fetch/data requesters and a random-latency memory drive the arbiter;
// a negedge monitor checks grants, holds, acks and returned data against queued expectations.
module tb_mem_port_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_bus  (bus)
    );

    typedef struct packed {
        logic        is_load;
        logic [31:0] val;
    } d_exp_t;

    int          n_vec    = 0;
    int          n_err    = 0;
    int          n_if_ack = 0;
    int          n_d_ack  = 0;
    bit          run      = 1'b0;
    bit          halt     = 1'b0;
    bit          mon_en   = 1'b0;
    bit          late_ack = 1'b0;
    logic [31:0] fq[$];
    d_exp_t      dq[$];
    logic [31:0] shadow[8];
    logic [31:0] phys[8];

    // Read-only instruction region content.
    function automatic logic [31:0] fmem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    function automatic logic [31:0] new_faddr();
        return 32'h1000 + (32'($urandom_range(0, 255)) << 2);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fetch requester: holds if_req until if_ack, occasionally redirects with a flush pulse.
    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (halt || !run) begin
                bus.if_req = 1'b0; bus.if_flush = 1'b0; fq.delete();
            end else begin
                bus.if_flush = 1'b0;
                if (bus.if_req && bus.if_ack) bus.if_req = 1'b0;
                if (bus.if_req && ($urandom_range(0, 7) == 0)) begin
                    bus.if_flush = 1'b1;
                    bus.if_addr  = new_faddr();
                    void'(fq.pop_back());
                    fq.push_back(fmem(bus.if_addr));
                end else if (!bus.if_req && ($urandom_range(0, 1) == 0)) begin
                    bus.if_req  = 1'b1;
                    bus.if_addr = new_faddr();
                    fq.push_back(fmem(bus.if_addr));
                end
            end
        end
    end

    // Data requester: random loads/stores into an 8-word region, shadow memory updated at issue.
    initial begin
        int          idx;
        d_exp_t      e;
        logic [31:0] wd;
        logic [3:0]  ws;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        for (int i = 0; i < 8; i++) shadow[i] = '0;
        forever begin
            @(posedge clk); #1;
            if (halt || !run) begin
                bus.d_req = 1'b0; dq.delete();
            end else begin
                if (bus.d_req && bus.d_ack) bus.d_req = 1'b0;
                if (!bus.d_req && ($urandom_range(0, 1) == 0)) begin
                    idx         = $urandom_range(0, 7);
                    bus.d_we    = 1'($urandom_range(0, 1));
                    wd          = $urandom;
                    ws          = 4'($urandom_range(1, 15));
                    bus.d_addr  = 32'h200 + 32'(idx * 4) + (bus.d_we ? 32'($urandom_range(0, 3)) : 32'h0);
                    bus.d_wdata = wd;
                    bus.d_wstrb = ws;
                    bus.d_req   = 1'b1;
                    if (bus.d_we) begin
                        for (int b = 0; b < 4; b++) if (ws[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
                        e.is_load = 1'b0; e.val = '0;
                    end else begin
                        e.is_load = 1'b1; e.val = shadow[idx];
                    end
                    dq.push_back(e);
                end
            end
        end
    end

    // Memory: random latency 1..5, single outstanding cycle, abandoned on reset.
    initial begin
        bit serving;
        int cnt;
        int idx;
        serving = 1'b0; cnt = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++) phys[i] = '0;
        forever begin
            @(posedge clk); #1;
            if (halt) begin
                serving = 1'b0; bus.mem_ack = late_ack;
            end else if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (bus.mem_req) begin
                if (!serving) begin serving = 1'b1; cnt = $urandom_range(1, 5); end
                cnt--;
                if (cnt == 0) begin
                    serving = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
                    if (bus.mem_addr >= 32'h200 && bus.mem_addr < 32'h220) begin
                        idx = int'((bus.mem_addr - 32'h200) >> 2);
                        if (bus.mem_we) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.mem_wstrb[b]) phys[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                        end else begin
                            bus.mem_rdata = phys[idx];
                        end
                    end else if (!bus.mem_we) begin
                        bus.mem_rdata = fmem(bus.mem_addr);
                    end
                end
            end
        end
    end

    // Monitor: grant choice, frozen memory outputs, ack timing/drop, stalls, returned data.
    initial begin
        bit          have_prev, txn_i, drop, grant, win_d, p_ri, p_rd, exp_if_ack, exp_d_ack;
        int          starve;
        logic [31:0] last_if;
        d_exp_t      e;
        logic        p_if_req, p_if_flush, p_if_ack, p_d_req, p_d_ack, p_d_we;
        logic        p_mem_req, p_mem_ack, p_mem_we;
        logic [31:0] p_if_addr, p_d_addr, p_d_wdata, p_mem_addr, p_mem_wdata;
        logic [3:0]  p_d_wstrb, p_mem_wstrb;
        have_prev = 1'b0; txn_i = 1'b0; drop = 1'b0; starve = 0; last_if = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || halt) begin
                have_prev = 1'b0;
                continue;
            end
            if (have_prev) begin
                exp_if_ack = 1'b0; exp_d_ack = 1'b0;
                if (!p_mem_req) begin
                    p_ri  = p_if_req && !p_if_flush && !p_if_ack;
                    p_rd  = p_d_req && !p_d_ack;
                    grant = p_ri || p_rd;
                    win_d = p_rd && !(p_ri && starve == SMAX);
                    check("grant", 128'(bus.mem_req), 128'(grant));
                    if (grant && bus.mem_req) begin
                        if (win_d)
                            check("grant_d_fields",
                                  {bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_we ? bus.mem_wdata : 32'h0},
                                  {p_d_we, p_d_addr, p_d_we ? p_d_wstrb : 4'h0, p_d_we ? p_d_wdata : 32'h0});
                        else
                            check("grant_i_fields", {bus.mem_we, bus.mem_addr, bus.mem_wstrb},
                                  {1'b0, p_if_addr, 4'h0});
                        txn_i = !win_d; drop = 1'b0;
                        if (win_d && p_ri && starve < SMAX) starve++;
                        if (!win_d) starve = 0;
                    end
                end else begin
                    if (txn_i && p_if_flush) drop = 1'b1;
                    if (p_mem_ack) begin
                        check("release", 128'(bus.mem_req), 128'(0));
                        if (txn_i) exp_if_ack = !drop; else exp_d_ack = 1'b1;
                    end else begin
                        check("hold", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb},
                              {1'b1, p_mem_we, p_mem_addr, p_mem_wdata, p_mem_wstrb});
                    end
                end
                if (!p_if_req) starve = 0;
                check("if_ack", 128'(bus.if_ack), 128'(exp_if_ack));
                check("d_ack", 128'(bus.d_ack), 128'(exp_d_ack));
            end
            check("stall_if", 128'(bus.stall_if), 128'(bus.if_req & ~bus.if_ack));
            check("stall_mem", 128'(bus.stall_mem), 128'(bus.d_req & ~bus.d_ack));
            if (bus.if_ack) begin
                n_if_ack++;
                if (fq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL if_ack_unexpected: got if_ack=1 expected no pending fetch at %0t", $time);
                end else begin
                    check("if_rdata", 128'(bus.if_rdata), 128'(fq.pop_front()));
                end
                last_if = bus.if_rdata;
            end else begin
                check("if_rdata_hold", 128'(bus.if_rdata), 128'(last_if));
            end
            if (bus.d_ack) begin
                n_d_ack++;
                if (dq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL d_ack_unexpected: got d_ack=1 expected no pending access at %0t", $time);
                end else begin
                    e = dq.pop_front();
                    if (e.is_load) check("d_rdata", 128'(bus.d_rdata), 128'(e.val));
                end
            end
            p_if_req = bus.if_req; p_if_flush = bus.if_flush; p_if_ack = bus.if_ack;
            p_if_addr = bus.if_addr; p_d_req = bus.d_req; p_d_ack = bus.d_ack; p_d_we = bus.d_we;
            p_d_addr = bus.d_addr; p_d_wdata = bus.d_wdata; p_d_wstrb = bus.d_wstrb;
            p_mem_req = bus.mem_req; p_mem_ack = bus.mem_ack; p_mem_we = bus.mem_we;
            p_mem_addr = bus.mem_addr; p_mem_wdata = bus.mem_wdata; p_mem_wstrb = bus.mem_wstrb;
            have_prev = 1'b1;
        end
    end

    // Sequencer: reset values, random traffic, then reset in the middle of a data access.
    initial begin
        bit found;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, 128'(0));
        check("rst_acks", {bus.if_ack, bus.d_ack}, 128'(0));
        check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 128'(0));
        check("rst_stall", {bus.stall_if, bus.stall_mem}, 128'(0));
        rst_n = 1'b1; mon_en = 1'b1; run = 1'b1;
        repeat (3000) @(posedge clk);
        #1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #1;
            if (bus.mem_req && bus.mem_addr >= 32'h200 && bus.mem_addr < 32'h220) found = 1'b1;
        end
        if (!found) begin
            n_vec++; n_err++;
            $display("FAIL busy_d_timeout: got no data transaction expected one within 300 cycles");
        end else begin
            halt = 1'b1; rst_n = 1'b0;
            @(posedge clk); #1;
            check("rst_mid_mem_req", 128'(bus.mem_req), 128'(0));
            check("rst_mid_acks", {bus.d_ack, bus.if_ack}, 128'(0));
            rst_n = 1'b1; late_ack = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            late_ack = 1'b0;
            for (int i = 0; i < 4; i++) begin
                check("late_ack_ignored", {bus.mem_req, bus.d_ack, bus.if_ack}, 128'(0));
                @(posedge clk); #1;
            end
        end
        check("progress_if", 128'(n_if_ack >= 20), 128'(1));
        check("progress_d", 128'(n_d_ack >= 20), 128'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
